// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI-Stream packet arbiter: round-robin grant held for a whole packet,
// with a per-packet completion report (source and saturating beat count).
module axis_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = $clog2(NUM_SRC)
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [NUM_SRC-1:0]         s_tvalid,
  input  logic [NUM_SRC-1:0]         s_tlast,
  input  logic [NUM_SRC*DATA_W-1:0]  s_tdata,
  output logic [NUM_SRC-1:0]         s_tready,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  output logic [DATA_W-1:0]          m_tdata,
  input  logic                       m_tready,
  output logic                       busy,
  output logic [SEL_W-1:0]           grant_id,
  output logic                       pkt_done,
  output logic [SEL_W-1:0]           pkt_src,
  output logic [CNT_W-1:0]           pkt_beats
);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_r, state_s;
  logic [SEL_W-1:0]   grant_id_r, grant_s, pick_s;
  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r, cnt_inc_s;
  logic               pkt_done_r;
  logic [SEL_W-1:0]   pkt_src_r;
  logic [CNT_W-1:0]   pkt_beats_r;
  logic               beat_s, last_beat_s;

  // First requester after 'last', wrapping modulo NUM_SRC; last itself is checked last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] sel;
    logic             found;
    idx   = last;
    sel   = last;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx   = (idx == SEL_W'(NUM_SRC - 1)) ? SEL_W'(0) : idx + SEL_W'(1);
      sel   = (!found && req[idx]) ? idx : sel;
      found = found | req[idx];
    end
    return sel;
  endfunction

  assign pick_s      = rr_pick(s_tvalid, grant_id_r);
  assign beat_s      = m_tvalid & m_tready;
  assign last_beat_s = beat_s & m_tlast;
  assign cnt_inc_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);

  // Output stream mux: only the granted source is connected, and only in XFER.
  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    s_tready = '0;
    if (state_r == XFER) begin
      m_tvalid           = s_tvalid[grant_id_r];
      m_tlast            = s_tlast[grant_id_r];
      m_tdata            = s_tdata[grant_id_r*DATA_W +: DATA_W];
      s_tready[grant_id_r] = m_tready;
    end else begin
      m_tvalid = 1'b0;
    end
  end

  // Next-state and grant selection.
  always_comb begin
    state_s = state_r;
    grant_s = grant_id_r;
    case (state_r)
      IDLE: begin
        if (|s_tvalid) begin
          state_s = XFER;
          grant_s = pick_s;
        end else begin
          state_s = IDLE;
        end
      end
      XFER: begin
        if (last_beat_s) begin
          state_s = IDLE;
        end else begin
          state_s = XFER;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, grant, beat counter and packet report registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r     <= IDLE;
      grant_id_r  <= SEL_W'(NUM_SRC - 1);
      busy_r      <= 1'b0;
      cnt_r       <= '0;
      pkt_done_r  <= 1'b0;
      pkt_src_r   <= '0;
      pkt_beats_r <= '0;
    end else begin
      state_r    <= state_s;
      grant_id_r <= grant_s;
      busy_r     <= (state_s == XFER);
      pkt_done_r <= last_beat_s;
      if (last_beat_s) begin
        pkt_src_r   <= grant_id_r;
        pkt_beats_r <= cnt_inc_s;
        cnt_r       <= '0;
      end else if (beat_s) begin
        cnt_r <= cnt_inc_s;
      end
    end
  end

  assign busy      = busy_r;
  assign grant_id  = grant_id_r;
  assign pkt_done  = pkt_done_r;
  assign pkt_src   = pkt_src_r;
  assign pkt_beats = pkt_beats_r;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: per-source beat queues drive the inputs,
// expected beats and packet reports are queued in the order the arbiter must serve them.
module tb_axis_rr_arbiter;
  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 3;
  localparam int SEL_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                      aclk = 1'b0;
  logic                      areset = 1'b1;
  logic [NUM_SRC-1:0]        s_tvalid, s_tlast, s_tready;
  logic [NUM_SRC*DATA_W-1:0] s_tdata;
  logic                      m_tvalid, m_tlast, m_tready;
  logic [DATA_W-1:0]         m_tdata;
  logic                      busy, pkt_done;
  logic [SEL_W-1:0]          grant_id, pkt_src;
  logic [CNT_W-1:0]          pkt_beats;

  axis_rr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .areset(areset),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tdata(s_tdata), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tready(m_tready),
    .busy(busy), .grant_id(grant_id),
    .pkt_done(pkt_done), .pkt_src(pkt_src), .pkt_beats(pkt_beats)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [DATA_W-1:0] data; logic last; int gap; } beat_t;
  typedef struct { logic [DATA_W-1:0] data; logic last; int src; } exp_beat_t;
  typedef struct { int src; int beats; } pkt_t;

  beat_t     src_q[NUM_SRC][$];
  exp_beat_t exp_beat_q[$];
  pkt_t      exp_pkt_q[$];
  logic      rdy_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int beats_seen = 0;
  int req_cyc = -1;
  logic lat_arm = 1'b0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [NUM_SRC-1:0] hs = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue a packet on a source and its expected output in serving order.
  task automatic send(input int src, input int n, input logic [31:0] base,
                      input int first_gap, input int mid_idx, input int mid_gap);
    beat_t bt;
    exp_beat_t e;
    pkt_t p;
    for (int b = 0; b < n; b++) begin
      bt.data = base + b;
      bt.last = (b == n - 1);
      bt.gap  = (b == 0) ? first_gap : ((b == mid_idx) ? mid_gap : 0);
      src_q[src].push_back(bt);
      e.data = bt.data;
      e.last = bt.last;
      e.src  = src;
      exp_beat_q.push_back(e);
    end
    p.src   = src;
    p.beats = (n > CNT_MAX) ? CNT_MAX : n;
    exp_pkt_q.push_back(p);
  endtask

  task automatic reset_checks();
    check_val("rst_busy", busy, 0);
    check_val("rst_grant_id", grant_id, NUM_SRC - 1);
    check_val("rst_m_tvalid", m_tvalid, 0);
    check_val("rst_s_tready", s_tready, 0);
    check_val("rst_pkt_done", pkt_done, 0);
    check_val("rst_pkt_src", pkt_src, 0);
    check_val("rst_pkt_beats", pkt_beats, 0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #1;
    reset_checks();
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    exp_beat_q.delete();
    exp_pkt_q.delete();
    rdy_q.delete();
    prev_stall = 1'b0;
    lat_arm = 1'b0;
    repeat (2) @(negedge aclk);
    #2;
    areset = 1'b0;
  endtask

  function automatic logic all_idle();
    logic r;
    r = (exp_beat_q.size() == 0) && (exp_pkt_q.size() == 0) && !busy;
    for (int i = 0; i < NUM_SRC; i++) r = r && (src_q[i].size() == 0);
    return r;
  endfunction

  task automatic drain(input string tag);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge aclk);
      #2;
      ok = all_idle();
    end
    check_val(tag, ok, 1);
  endtask

  // Monitor at negedge, source/sink driver just after posedge.
  initial begin : drv_mon
    exp_beat_t e;
    pkt_t p;
    beat_t h;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    forever begin
      @(negedge aclk);
      if (!areset) begin
        hs = s_tvalid & s_tready;
        if (prev_stall) begin
          check_val("stall_valid", m_tvalid, 1);
          check_val("stall_hold", m_tdata, prev_data);
        end
        prev_stall = m_tvalid & ~m_tready;
        prev_data  = m_tdata;
        if (m_tvalid && m_tready) begin
          beats_seen++;
          if (lat_arm) begin
            check_val("first_beat_latency", cyc - req_cyc, 1);
            lat_arm = 1'b0;
          end
          check_val("beat_expected", exp_beat_q.size() > 0, 1);
          if (exp_beat_q.size() > 0) begin
            e = exp_beat_q.pop_front();
            check_val("m_tdata", m_tdata, e.data);
            check_val("m_tlast", m_tlast, e.last);
            check_val("beat_grant_id", grant_id, e.src);
            check_val("beat_busy", busy, 1);
          end
        end
        if (pkt_done) begin
          check_val("pkt_expected", exp_pkt_q.size() > 0, 1);
          check_val("bubble_busy", busy, 0);
          if (exp_pkt_q.size() > 0) begin
            p = exp_pkt_q.pop_front();
            check_val("pkt_src", pkt_src, p.src);
            check_val("pkt_beats", pkt_beats, p.beats);
          end
        end
      end
      @(posedge aclk);
      #1;
      if (areset) begin
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        hs = '0;
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
          if (src_q[i].size() > 0) begin
            h = src_q[i].pop_front();
            if (h.gap > 0) begin
              s_tvalid[i] = 1'b0;
              h.gap--;
            end else begin
              s_tvalid[i] = 1'b1;
              s_tdata[i*DATA_W +: DATA_W] = h.data;
              s_tlast[i] = h.last;
            end
            src_q[i].push_front(h);
          end else begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
          end
        end
        m_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        if (lat_arm && req_cyc < 0 && |s_tvalid) req_cyc = cyc;
        hs = '0;
      end
    end
  end

  initial begin : scenarios
    logic ok;
    int start;
    repeat (3) @(negedge aclk);
    reset_checks();
    #2;
    areset = 1'b0;
    @(negedge aclk);
    #2;
    reset_checks();

    // 3-beat packet from src1 with first-beat latency check
    req_cyc = -1;
    lat_arm = 1'b1;
    send(1, 3, 32'hAAAA_0001, 0, -1, 0);
    drain("drain_single_src");

    // src0 and src2 from reset alternate 0,2,0,2
    @(negedge aclk); #2; do_reset();
    send(0, 2, 32'hC200_0000, 0, -1, 0);
    send(2, 3, 32'hC200_0100, 0, -1, 0);
    send(0, 1, 32'hC200_0200, 0, -1, 0);
    send(2, 1, 32'hC200_0300, 0, -1, 0);
    drain("drain_alternate");

    // all four sources with 1-beat packets: 0,1,2,3,0
    @(negedge aclk); #2; do_reset();
    send(0, 1, 32'hC300_0000, 0, -1, 0);
    send(1, 1, 32'hC300_0100, 0, -1, 0);
    send(2, 1, 32'hC300_0200, 0, -1, 0);
    send(3, 1, 32'hC300_0300, 0, -1, 0);
    send(0, 1, 32'hC300_0400, 0, -1, 0);
    drain("drain_all_four");

    // src3 stalled by sink 1,0,0,1 while src0 requests mid-packet
    send(3, 4, 32'hC400_0000, 0, -1, 0);
    send(0, 2, 32'hC400_0100, 4, -1, 0);
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    drain("drain_stall");

    // src2 drops valid for 2 cycles mid-packet while src1 requests
    send(2, 4, 32'hC500_0000, 0, 2, 2);
    send(1, 1, 32'hC500_0100, 2, -1, 0);
    drain("drain_valid_gap");

    // beat counter saturates at CNT_MAX, data still forwarded
    send(3, 10, 32'hC600_0000, 0, -1, 0);
    drain("drain_saturate");

    // reset on beat 2 of a 4-beat packet, then source 0 wins over source 2
    start = beats_seen;
    send(1, 4, 32'hC700_0000, 0, -1, 0);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge aclk);
      #2;
      ok = (beats_seen >= start + 2);
    end
    check_val("reset_mid_reach", ok, 1);
    do_reset();
    repeat (3) @(negedge aclk);
    #2;
    send(0, 1, 32'hC800_0000, 0, -1, 0);
    send(2, 1, 32'hC800_0100, 0, -1, 0);
    drain("drain_after_reset");

    repeat (3) @(negedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
